lfsr_1: RTL and testbench
=========================

# lfsr_1

Free-running 28-bit maximal-length pseudo-random sequence generator. It is a Fibonacci LFSR that advances one step every clock after reset. It sources test patterns and dither/scrambler streams for downstream datapath blocks. Its output sequence is bit-exact against the team's software model, which emits one decimal value per cycle.

## Interface
- WIDTH, 28, state/output width; legal range 2..32.
- TAPS, `28'h9000000` (x^28 + x^25 + 1), feedback tap mask. Bit i set means state bit i feeds the XOR. The MSB must always be set.
  - An internal maximal-length tap table keyed by WIDTH supplies the default when WIDTH ≠ 28.
- SEED, `28'h0000001`, state loaded on reset. A SEED of all-zero is illegal; the block substitutes 1.
- clk  input  1  single clock; all state changes on its rising edge.
- resetn  input  1  synchronous, active-high reset (the `n` suffix is historical; asserted = 1).
- lfsr_out  output  WIDTH  current LFSR state, driven directly from the state register.

## Operation
- Feedback bit: fb = XOR over all state bits i with TAPS[i]=1. For the default this is fb = q[27] ^ q[24].
- Update: q_next = {q[WIDTH-2:0], fb}. The register shifts left, fb enters at the LSB, and q[WIDTH-1] is discarded.
- No enable input: the state advances on every rising edge while resetn=0.
- Reset: a rising edge with resetn=1 loads SEED (or 1 if SEED==0). Reset has priority over everything else.
- Period is 2^WIDTH − 1 for any non-zero state. All-zero is a lock-up state, unreachable from a legal seed.
- Default sequence from SEED=1, starting at the first edge after reset release:
  - cycles 1..24: 0x0000002, 0x0000004 … 0x1000000 (a single bit walking left).
  - cycle 25: 0x2000001.
  - cycle 26: 0x4000002.
  - cycle 27: 0x8000004.
  - cycle 28: 0x0000009.
- lfsr_out is unsigned; the software model compares it as an unsigned decimal integer.

## Timing
- Reset value of lfsr_out: SEED, visible after the rising edge that samples resetn=1.
- Holding resetn=1 for N edges keeps lfsr_out at SEED throughout.
- Latency: lfsr_out changes exactly once per rising edge, one state step per cycle.
- lfsr_out is a pure register output: no combinational path from any input.
- resetn deasserted at edge k: the edge at which resetn is sampled 0 produces state step 1.
- Reset asserted mid-sequence: the next rising edge reloads SEED regardless of the current state. The sequence restarts identically.
- Power-up before the first reset: the state is undefined. Verification ignores outputs until after reset.

## Configuration
- LFSR1_LOCKUP_RECOVER_EN defined:
  - If the state is all-zero at a rising edge with resetn=0, the next state is SEED (or 1).
  - This guards against an X or upset-induced zero state.
- Macro undefined:
  - No detection logic is built; an all-zero state stays all-zero forever.
  - Behaviour from any non-zero state is identical in both builds.

## Test plan
- Reset then run: resetn=1 for one edge, then 0. lfsr_out must equal 0x0000001 after reset, then 0x0000002, 0x0000004, …, with cycle 25 = 0x2000001 and cycle 28 = 0x0000009.
- Golden compare: capture 256 consecutive lfsr_out values starting at the first edge after reset release. All must match the software model's decimal file with zero mismatches.
- Mid-run reset: run 100 cycles, assert resetn for 1 edge. lfsr_out must become 0x0000001, and the following 28 values must repeat the reset-then-run sequence exactly.
- Reset hold: keep resetn=1 for 10 edges. lfsr_out must stay 0x0000001 for all 10 edges.
- Period/non-zero check (WIDTH=8 override): run 300 cycles. lfsr_out must never be 0, must return to SEED after exactly 255 steps, and all 255 states must be distinct.
- Lock-up (LFSR1_LOCKUP_RECOVER_EN defined): force the state to 0 for one cycle, then release. The next edge must give lfsr_out = 0x0000001. With the macro undefined, lfsr_out must stay 0.

Source files
------------

// File: rtl/lfsr_1.sv
// Free-running Fibonacci LFSR, shift-left with feedback into the LSB.
// Optional build macro LFSR1_LOCKUP_RECOVER_EN reseeds the register out of the all-zero state.
module lfsr_1 #(
  parameter int          WIDTH = 28,
  parameter logic [31:0] TAPS  = 32'h0900_0000,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             resetn,
  output logic [WIDTH-1:0] lfsr_out
);

  // Maximal-length tap masks; bit i set means state bit i feeds the XOR.
  function automatic logic [31:0] tap_table(input int w);
    logic [31:0] t;
    case (w)
      2:       t = 32'h0000_0003;
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      32:      t = 32'h8020_0003;
      default: t = 32'h0900_0000;
    endcase
    return t;
  endfunction

  // An untouched TAPS on a non-28-bit build means "pick from the table".
  localparam logic [31:0] TAPS_SEL =
    (WIDTH != 28 && TAPS == 32'h0900_0000) ? tap_table(WIDTH) : TAPS;
  localparam logic [WIDTH-1:0] TAP_MASK =
    TAPS_SEL[WIDTH-1:0] | {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SEED_RAW = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED_RAW == '0) ? WIDTH'(1) : SEED_RAW;

  logic [WIDTH-1:0] q;
  logic             fb;

  assign fb = ^(q & TAP_MASK);

  always_ff @(posedge clk) begin
    if (resetn)
      q <= SEED_EFF;
`ifdef LFSR1_LOCKUP_RECOVER_EN
    else if (q == '0)
      q <= SEED_EFF;
`endif
    else
      q <= {q[WIDTH-2:0], fb};
  end

  assign lfsr_out = q;

endmodule

// File: tb/tb_lfsr_1.sv
// Bench for lfsr_1: vector table, golden/random-reset compare against an arithmetic
// model, mid-run reset, reset hold, WIDTH=8 period properties and lock-up behaviour.
module tb_lfsr_1;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        rst8 = 1'b1;
  logic [27:0] lfsr_out;
  logic [7:0]  out8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_1 dut (.clk(clk), .resetn(resetn), .lfsr_out(lfsr_out));
  lfsr_1 #(.WIDTH(8)) dut8 (.clk(clk), .resetn(rst8), .lfsr_out(out8));

  typedef struct {
    logic        rst;
    logic [27:0] exp;
  } vec_t;

  vec_t tbl[29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec rule: fb = parity of tapped bits; next = (2*s + fb) mod 2^w.
  function automatic longint unsigned adv(input longint unsigned s,
                                          input longint unsigned taps, input int w);
    int fb;
    fb = $countones(s & taps) % 2;
    return (s * 2 + longint'(fb)) % (64'd1 << w);
  endfunction

  initial begin
    logic [27:0]       one;
    longint unsigned   m;
    logic              r;
    bit                seen [256];
    int                first_ret;
    int                distinct;
    int                hit;

    one = 28'd1;
    tbl[0] = '{1'b1, 28'h0000001};
    for (int c = 1; c <= 24; c++) tbl[c] = '{1'b0, one << c};
    tbl[25] = '{1'b0, 28'h2000001};
    tbl[26] = '{1'b0, 28'h4000002};
    tbl[27] = '{1'b0, 28'h8000004};
    tbl[28] = '{1'b0, 28'h0000009};

    // Reset, then reset hold for 10 edges.
    resetn = 1'b1;
    step();
    chk("reset_value", lfsr_out, 32'h1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("reset_hold", lfsr_out, 32'h1);
    end

    // Reset-then-run vector table.
    for (int i = 0; i < 29; i++) begin
      resetn = tbl[i].rst;
      step();
      chk($sformatf("vec%0d", i), lfsr_out, tbl[i].exp);
    end

    // Golden 256 values after reset release.
    resetn = 1'b1;
    step();
    resetn = 1'b0;
    m = 1;
    for (int i = 0; i < 256; i++) begin
      step();
      m = adv(m, 64'h9000000, 28);
      chk("golden", lfsr_out, 32'(m));
    end

    // Random reset pulses against the model.
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 39) == 0);
      resetn = r;
      step();
      m = r ? 64'd1 : adv(m, 64'h9000000, 28);
      chk("random", lfsr_out, 32'(m));
    end

    // Mid-run reset: 100 cycles, one reset edge, then sequence repeats.
    resetn = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      m = adv(m, 64'h9000000, 28);
      chk("midrun_pre", lfsr_out, 32'(m));
    end
    resetn = 1'b1;
    step();
    chk("midrun_reset", lfsr_out, 32'h1);
    for (int i = 1; i < 29; i++) begin
      resetn = tbl[i].rst;
      step();
      chk($sformatf("midrun_vec%0d", i), lfsr_out, tbl[i].exp);
    end

    // WIDTH=8 period and distinctness.
    rst8 = 1'b1;
    step();
    chk("w8_reset", {24'd0, out8}, 32'h1);
    rst8 = 1'b0;
    first_ret = -1;
    distinct = 0;
    for (int i = 1; i <= 300; i++) begin
      step();
      chk("w8_nonzero", {31'd0, out8 != 8'd0}, 32'h1);
      if (i <= 255 && !seen[out8]) begin
        seen[out8] = 1'b1;
        distinct++;
      end
      if (first_ret < 0 && out8 == 8'd1) first_ret = i;
    end
    chk("w8_period", first_ret, 255);
    chk("w8_distinct", distinct, 255);

    // Lock-up: force the state to zero across one edge, then release.
    resetn = 1'b0;
    @(negedge clk);
    force dut.q = '0;
    step();
    @(negedge clk);
    release dut.q;
`ifdef LFSR1_LOCKUP_RECOVER_EN
    hit = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (lfsr_out == 28'h1) hit = 1;
    end
    chk("lockup_recover", hit, 1);
`else
    hit = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("lockup_stuck", lfsr_out, 32'h0);
    end
`endif

    // Reset pulls it back from anything.
    resetn = 1'b1;
    step();
    chk("final_reset", lfsr_out, 32'h1);
    resetn = 1'b0;
    step();
    chk("final_step", lfsr_out, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
